// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
package snake_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT, S_INIT_Q, S_WAIT, S_HEAD, S_MOVE, S_CHECK,
    S_SHIFT, S_SH_RD, S_SH_LD, S_SH_WR, S_ERASE,
    S_DRAW, S_DR_RD, S_DR_PX, S_FOOD, S_DEAD
  } state_t;

  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;

  localparam logic [2:0] COL_DRAW  = 3'b111;
  localparam logic [2:0] COL_ERASE = 3'b000;

  localparam int unsigned CELL_PIXELS = 9;
  localparam int unsigned PIX_W       = 4;

  // Direction pointing the opposite way on the same axis.
  function automatic logic [2:0] dir_reverse(input logic [2:0] d);
    return d[2] ? {d[2], ~d[1], d[0]} : {d[2], d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Key priority encoder with reversal rejection; holds the pending direction.
module snake_dir_filter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [2:0] dir,
  output logic [2:0] next_dir
);

  logic       req_valid;
  logic [2:0] req_dir;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if (key_up)         req_dir = DIR_UP;
    else if (key_down)  req_dir = DIR_DOWN;
    else if (key_left)  req_dir = DIR_LEFT;
    else if (key_right) req_dir = DIR_RIGHT;
    else                req_valid = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_dir <= DIR_UP;
    end else if (req_valid && (req_dir != dir_reverse(dir))) begin
      next_dir <= req_dir;
    end
  end

endmodule

// File: rtl/snake_control.sv
// Sequencer for the snake datapath: initial body build, then one move/grow/redraw step per tick.
module snake_control
  import snake_pkg::*;
#(
  parameter int unsigned INIT_LEN    = 4,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TICK_CYCLES = 2500000,
  parameter int unsigned ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              isDead,
  input  logic              inc_length,
  output logic              ld_head,
  output logic              ld_q_def,
  output logic              inc_address,
  output logic              rst_address,
  output logic              update_head,
  output logic              ld_head_into_prev,
  output logic              ld_q_into_curr,
  output logic              ld_prev_into_q,
  output logic              ld_curr_into_prev,
  output logic              draw_q,
  output logic              draw_curr,
  output logic              food_en,
  output logic              lock,
  output logic              check_inc,
  output logic [3:0]        cnt_status,
  output logic [2:0]        dir,
  output logic [2:0]        colour,
  output logic [ADDR_W-1:0] length,
  output logic              game_over
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [ADDR_W-1:0]   seg_cnt, seg_nxt;
  logic [PIX_W-1:0]    pix_cnt, pix_nxt;
  logic [ADDR_W-1:0]   length_nxt;
  logic [2:0]          dir_nxt, next_dir;
  logic                grow, grow_nxt;
  logic                last_seg, last_pix;

  snake_dir_filter u_dir_filter (
    .clk       (clk),
    .rst       (rst),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .dir       (dir),
    .next_dir  (next_dir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      seg_cnt  <= '0;
      pix_cnt  <= '0;
      length   <= ADDR_W'(INIT_LEN);
      grow     <= 1'b0;
      dir      <= DIR_UP;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      seg_cnt  <= seg_nxt;
      pix_cnt  <= pix_nxt;
      length   <= length_nxt;
      grow     <= grow_nxt;
      dir      <= dir_nxt;
    end
  end

  assign last_seg = (seg_cnt == length - ADDR_W'(1));
  assign last_pix = (pix_cnt == PIX_W'(CELL_PIXELS - 1));

  always_comb begin
    state_nxt         = state;
    tick_nxt          = tick_cnt;
    seg_nxt           = seg_cnt;
    pix_nxt           = pix_cnt;
    length_nxt        = length;
    grow_nxt          = grow;
    dir_nxt           = dir;
    ld_head           = 1'b0;
    ld_q_def          = 1'b0;
    inc_address       = 1'b0;
    rst_address       = 1'b0;
    update_head       = 1'b0;
    ld_head_into_prev = 1'b0;
    ld_q_into_curr    = 1'b0;
    ld_prev_into_q    = 1'b0;
    ld_curr_into_prev = 1'b0;
    draw_q            = 1'b0;
    draw_curr         = 1'b0;
    food_en           = 1'b0;
    lock              = 1'b0;
    check_inc         = 1'b0;
    cnt_status        = 4'd0;
    colour            = COL_ERASE;
    game_over         = 1'b0;

    case (state)
      S_IDLE: if (go) state_nxt = S_INIT;
      S_INIT: begin
        ld_head     = 1'b1;
        rst_address = 1'b1;
        seg_nxt     = '0;
        state_nxt   = S_INIT_Q;
      end
      S_INIT_Q: begin
        ld_q_def    = 1'b1;
        inc_address = 1'b1;
        if (seg_cnt == ADDR_W'(INIT_LEN - 1)) begin
          seg_nxt   = '0;
          tick_nxt  = '0;
          state_nxt = S_WAIT;
        end else begin
          seg_nxt = seg_cnt + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
          tick_nxt  = '0;
          state_nxt = S_HEAD;
        end else begin
          tick_nxt = tick_cnt + TICK_W'(1);
        end
      end
      S_HEAD: begin
        dir_nxt   = next_dir;
        state_nxt = S_MOVE;
      end
      S_MOVE: begin
        update_head = 1'b1;
        state_nxt   = S_CHECK;
      end
      // Food hit at full length is consumed without growing.
      S_CHECK: begin
        check_inc = 1'b1;
        lock      = 1'b1;
        grow_nxt  = inc_length && (32'(length) < MAX_LEN);
        if (grow_nxt) length_nxt = length + ADDR_W'(1);
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        ld_head_into_prev = 1'b1;
        rst_address       = 1'b1;
        seg_nxt           = '0;
        state_nxt         = S_SH_RD;
      end
      S_SH_RD: state_nxt = S_SH_LD;
      S_SH_LD: begin
        ld_q_into_curr = 1'b1;
        state_nxt      = S_SH_WR;
      end
      S_SH_WR: begin
        ld_prev_into_q    = 1'b1;
        ld_curr_into_prev = 1'b1;
        inc_address       = 1'b1;
        if (last_seg) begin
          seg_nxt   = '0;
          pix_nxt   = '0;
          state_nxt = grow ? S_DRAW : S_ERASE;
        end else begin
          seg_nxt   = seg_cnt + ADDR_W'(1);
          state_nxt = S_SH_RD;
        end
      end
      // Old tail is left in curr after the shift; blank its cell.
      S_ERASE: begin
        draw_curr  = 1'b1;
        cnt_status = pix_cnt;
        if (last_pix) begin
          pix_nxt   = '0;
          state_nxt = S_DRAW;
        end else begin
          pix_nxt = pix_cnt + PIX_W'(1);
        end
      end
      S_DRAW: begin
        rst_address = 1'b1;
        seg_nxt     = '0;
        pix_nxt     = '0;
        state_nxt   = S_DR_RD;
      end
      S_DR_RD: state_nxt = S_DR_PX;
      S_DR_PX: begin
        draw_q     = 1'b1;
        colour     = COL_DRAW;
        cnt_status = pix_cnt;
        if (last_pix) begin
          pix_nxt     = '0;
          inc_address = 1'b1;
          if (last_seg) begin
            seg_nxt   = '0;
            state_nxt = S_FOOD;
          end else begin
            seg_nxt   = seg_cnt + ADDR_W'(1);
            state_nxt = S_DR_RD;
          end
        end else begin
          pix_nxt = pix_cnt + PIX_W'(1);
        end
      end
      S_FOOD: begin
        food_en   = 1'b1;
        colour    = COL_DRAW;
        tick_nxt  = '0;
        state_nxt = isDead ? S_DEAD : S_WAIT;
      end
      S_DEAD: game_over = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_snake_control.sv
// Scoreboard bench: per-step strobe tallies are checked against hand-computed records at food_en.
module tb_snake_control;

  localparam int unsigned INIT_LEN    = 4;
  localparam int unsigned MAX_LEN     = 6;
  localparam int unsigned TICK_CYCLES = 10;
  localparam int unsigned ADDR_W      = 11;

  logic clk = 1'b0;
  logic rst, go, key_up, key_down, key_left, key_right, isDead, inc_length;
  logic ld_head, ld_q_def, inc_address, rst_address, update_head, ld_head_into_prev;
  logic ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_q, draw_curr;
  logic food_en, lock, check_inc, game_over;
  logic [3:0] cnt_status;
  logic [2:0] dir, colour;
  logic [ADDR_W-1:0] length;
  logic any_strobe;

  always #5 clk = ~clk;

  snake_control #(
    .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .TICK_CYCLES(TICK_CYCLES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .isDead(isDead), .inc_length(inc_length),
    .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address),
    .rst_address(rst_address), .update_head(update_head),
    .ld_head_into_prev(ld_head_into_prev), .ld_q_into_curr(ld_q_into_curr),
    .ld_prev_into_q(ld_prev_into_q), .ld_curr_into_prev(ld_curr_into_prev),
    .draw_q(draw_q), .draw_curr(draw_curr), .food_en(food_en), .lock(lock),
    .check_inc(check_inc), .cnt_status(cnt_status), .dir(dir), .colour(colour),
    .length(length), .game_over(game_over)
  );

  assign any_strobe = ld_head | ld_q_def | inc_address | rst_address | update_head |
                      ld_head_into_prev | ld_q_into_curr | ld_prev_into_q |
                      ld_curr_into_prev | draw_q | draw_curr | food_en | lock | check_inc;

  typedef struct {
    int defq;
    int upd;
    int shld;
    int erase;
    int drawq;
    int len;
    int dir;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int steps_seen = 0;
  int n_defq, n_defq_inc, n_upd, n_shld, n_shwr, n_erase, n_drawq, n_colbad, n_pixbad;
  int pix_exp;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_tally();
    n_defq = 0; n_defq_inc = 0; n_upd = 0; n_shld = 0; n_shwr = 0;
    n_erase = 0; n_drawq = 0; n_colbad = 0; n_pixbad = 0; pix_exp = 0;
  endtask

  task automatic push(input int defq, input int shld, input int erase,
                      input int drawq, input int len, input int d);
    exp_t e;
    e.defq = defq; e.upd = 1; e.shld = shld; e.erase = erase;
    e.drawq = drawq; e.len = len; e.dir = d;
    exp_q.push_back(e);
  endtask

  // Tallies strobes each cycle and scores one step record whenever food_en appears.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        clear_tally();
      end else begin
        n_defq     += int'(ld_q_def);
        n_defq_inc += int'(ld_q_def && inc_address);
        n_upd      += int'(update_head);
        n_shld     += int'(ld_q_into_curr);
        n_shwr     += int'(ld_prev_into_q && ld_curr_into_prev && inc_address);
        n_erase    += int'(draw_curr);
        n_drawq    += int'(draw_q);
        if (draw_curr && colour != 3'b000) n_colbad++;
        if ((draw_q || food_en) && colour != 3'b111) n_colbad++;
        if (draw_curr || draw_q) begin
          if (int'(cnt_status) != pix_exp) n_pixbad++;
          pix_exp = (pix_exp == 8) ? 0 : pix_exp + 1;
        end
        if (food_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_step", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("init_ld_q_def", n_defq, e.defq);
            chk("init_inc_address", n_defq_inc, e.defq);
            chk("update_head", n_upd, e.upd);
            chk("shift_ld", n_shld, e.shld);
            chk("shift_wr", n_shwr, e.shld);
            chk("erase_cycles", n_erase, e.erase);
            chk("draw_q_cycles", n_drawq, e.drawq);
            chk("length", int'(length), e.len);
            chk("dir", int'(dir), e.dir);
            chk("colour_errors", n_colbad, 0);
            chk("pixel_errors", n_pixbad, 0);
          end
          clear_tally();
          steps_seen++;
        end
      end
    end
  endtask

  task automatic wait_step();
    int tgt;
    int n;
    tgt = steps_seen + 1;
    n = 0;
    while (steps_seen < tgt && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (steps_seen < tgt) chk("step_timeout", 0, 1);
  endtask

  task automatic wait_sig_draw_q();
    int n;
    n = 0;
    while (!draw_q && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!draw_q) chk("draw_q_timeout", 0, 1);
  endtask

  task automatic wait_sig_shift();
    int n;
    n = 0;
    while (!ld_q_into_curr && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!ld_q_into_curr) chk("shift_timeout", 0, 1);
  endtask

  initial begin
    int strobe_hits;
    rst = 1'b1; go = 1'b0; isDead = 1'b0; inc_length = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    clear_tally();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_strobes", int'(any_strobe), 0);
    chk("rst_dir", int'(dir), 4);
    chk("rst_length", int'(length), 4);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_cnt_status", int'(cnt_status), 0);
    rst = 1'b0;

    // Step 1: initial build plus a plain move.
    push(4, 4, 9, 36, 4, 4);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_step();

    // Step 2: down while moving up is a reversal.
    key_down = 1'b1;
    push(0, 4, 9, 36, 4, 4);
    wait_step();
    key_down = 1'b0;

    // Step 3: left beats right.
    key_left = 1'b1; key_right = 1'b1;
    push(0, 4, 9, 36, 4, 0);
    wait_step();
    key_left = 1'b0; key_right = 1'b0;

    // Step 4: food hit grows to 5, no erase.
    inc_length = 1'b1;
    push(0, 5, 0, 45, 5, 0);
    wait_step();

    // Step 5: grow to 6; right while moving left is rejected.
    key_right = 1'b1;
    push(0, 6, 0, 54, 6, 0);
    wait_step();
    key_right = 1'b0;

    // Step 6: at the cap, food is consumed but length holds and the tail is erased.
    push(0, 6, 9, 54, 6, 0);
    wait_step();
    inc_length = 1'b0;

    // Reset during the body shift.
    wait_sig_shift();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", int'(any_strobe), 0);
    chk("midrst_dir", int'(dir), 4);
    chk("midrst_length", int'(length), 4);
    chk("midrst_game_over", int'(game_over), 0);
    chk("midrst_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    strobe_hits = 0;
    repeat (5) begin
      @(negedge clk);
      strobe_hits += int'(any_strobe);
    end
    chk("idle_after_rst", strobe_hits, 0);

    // Fresh game turning left, dying during the redraw.
    key_left = 1'b1;
    push(4, 4, 9, 36, 4, 0);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_sig_draw_q();
    isDead = 1'b1;
    wait_step();
    key_left = 1'b0;
    @(negedge clk);
    chk("dead_game_over", int'(game_over), 1);
    strobe_hits = 0;
    repeat (1000) begin
      @(negedge clk);
      strobe_hits += int'(any_strobe);
    end
    chk("dead_strobes", strobe_hits, 0);
    chk("dead_hold", int'(game_over), 1);
    chk("steps_scored", steps_seen, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
